// File: rtl/kernel_cc_fifo_pkg.sv
// Shared sizing helpers and default parameters for the kernel_cc SRL FIFO family.
package kernel_cc_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 32;

    function automatic int fifo_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return fifo_addr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/kernel_cc_fifo_srl_param_shiftreg.sv
// Purpose: un-reset shift-register storage; entry 0 takes data on ce, the rest shift up.
// Latency: write visible at q one cycle later; q is a combinational read of entry a.
// Backpressure: none here, the enclosing FIFO gates ce.
module kernel_cc_fifo_srl_param_shiftreg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            mem[0] <= data;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign q = mem[a];

endmodule

// File: rtl/kernel_cc_fifo_srl_param.sv
// Purpose: parametrised FWFT shift-register FIFO with occupancy count and registered almost flags.
// Latency: one cycle write-to-dout; flags and count registered from next occupancy.
// Backpressure: if_full_n low drops writes, if_empty_n low drops reads; KERNEL_CC_FIFO_ERR_EN adds sticky error flags.
module kernel_cc_fifo_srl_param
    import kernel_cc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = fifo_addr_w(DEPTH),
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_full,
    output logic                  if_almost_empty
`ifdef KERNEL_CC_FIFO_ERR_EN
    ,
    output logic                  if_overflow,
    output logic                  if_underflow
`endif
);

    localparam int CW = ADDR_WIDTH + 1;

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "kernel_cc_fifo_srl_param: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "kernel_cc_fifo_srl_param: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "kernel_cc_fifo_srl_param: AE_THRESH must be in 0..DEPTH-1");
    end

    logic                  wr_acc;
    logic                  rd_acc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         count_m1;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign wr_acc = if_write & if_write_ce & if_full_n;
    assign rd_acc = if_read & if_read_ce & if_empty_n;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Oldest word sits at count-1 because every write pushes the others up.
    assign count_m1 = count - CW'(1);
    assign rd_addr  = (count != '0) ? count_m1[ADDR_WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count           <= '0;
            if_empty_n      <= 1'b0;
            if_full_n       <= 1'b1;
            if_almost_full  <= 1'b0;
            if_almost_empty <= 1'b1;
        end else begin
            count           <= count_nxt;
            if_empty_n      <= (count_nxt != '0);
            if_full_n       <= (count_nxt != CW'(DEPTH));
            if_almost_full  <= (count_nxt >= CW'(AF_THRESH));
            if_almost_empty <= (count_nxt <= CW'(AE_THRESH));
        end
    end

    assign if_count = count;

`ifdef KERNEL_CC_FIFO_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_overflow  <= 1'b0;
            if_underflow <= 1'b0;
        end else begin
            if_overflow  <= if_overflow  | (if_write & if_write_ce & ~if_full_n);
            if_underflow <= if_underflow | (if_read & if_read_ce & ~if_empty_n);
        end
    end
`endif

    kernel_cc_fifo_srl_param_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (clk),
        .data (if_din),
        .ce   (wr_acc),
        .a    (rd_addr),
        .q    (if_dout)
    );

endmodule

// File: tb/tb_kernel_cc_fifo_srl_param.sv
// Randomised and directed bench for kernel_cc_fifo_srl_param (DEPTH=5, 8-bit) with a queue reference model.
module tb_kernel_cc_fifo_srl_param;

    localparam int DW = 8;
    localparam int DEPTH = 5;
    localparam int AW = 3;
    localparam int AF = 4;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          if_write = 1'b0;
    logic          if_write_ce = 1'b0;
    logic          if_full_n;
    logic [DW-1:0] if_dout;
    logic          if_read = 1'b0;
    logic          if_read_ce = 1'b0;
    logic          if_empty_n;
    logic [AW:0]   if_count;
    logic          if_almost_full;
    logic          if_almost_empty;
`ifdef KERNEL_CC_FIFO_ERR_EN
    logic          if_overflow;
    logic          if_underflow;
    logic          ov_exp = 1'b0;
    logic          un_exp = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mq [$];

    always #5 clk = ~clk;

    kernel_cc_fifo_srl_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_din          (if_din),
        .if_write        (if_write),
        .if_write_ce     (if_write_ce),
        .if_full_n       (if_full_n),
        .if_dout         (if_dout),
        .if_read         (if_read),
        .if_read_ce      (if_read_ce),
        .if_empty_n      (if_empty_n),
        .if_count        (if_count),
        .if_almost_full  (if_almost_full),
        .if_almost_empty (if_almost_empty)
`ifdef KERNEL_CC_FIFO_ERR_EN
        ,
        .if_overflow     (if_overflow),
        .if_underflow    (if_underflow)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks status against the queue model, pops on reads, pushes on writes.
    always @(negedge clk) begin : monitor
        int n;
        n = mq.size();
        if (!reset_n) begin
            chk("rst_count", 32'(if_count), 0);
            chk("rst_empty_n", 32'(if_empty_n), 0);
            chk("rst_full_n", 32'(if_full_n), 1);
            chk("rst_af", 32'(if_almost_full), 0);
            chk("rst_ae", 32'(if_almost_empty), 1);
            mq.delete();
`ifdef KERNEL_CC_FIFO_ERR_EN
            chk("rst_ovf", 32'(if_overflow), 0);
            chk("rst_unf", 32'(if_underflow), 0);
            ov_exp = 1'b0;
            un_exp = 1'b0;
`endif
        end else begin
            chk("count", 32'(if_count), 32'(n));
            chk("empty_n", 32'(if_empty_n), 32'(n != 0));
            chk("full_n", 32'(if_full_n), 32'(n != DEPTH));
            chk("almost_full", 32'(if_almost_full), 32'(n >= AF));
            chk("almost_empty", 32'(if_almost_empty), 32'(n <= AE));
`ifdef KERNEL_CC_FIFO_ERR_EN
            chk("overflow", 32'(if_overflow), 32'(ov_exp));
            chk("underflow", 32'(if_underflow), 32'(un_exp));
            if (if_write && if_write_ce && n == DEPTH) ov_exp = 1'b1;
            if (if_read && if_read_ce && n == 0) un_exp = 1'b1;
`endif
            if (if_read && if_read_ce && n > 0) begin
                chk("dout", 32'(if_dout), 32'(mq[0]));
                void'(mq.pop_front());
            end
            if (if_write && if_write_ce && n < DEPTH) mq.push_back(if_din);
        end
    end

    task automatic drv(input logic w, input logic wce, input logic [DW-1:0] d,
                       input logic r, input logic rce);
        if_write    = w;
        if_write_ce = wce;
        if_din      = d;
        if_read     = r;
        if_read_ce  = rce;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Fill with 0x11..0x15.
        for (int i = 0; i < DEPTH; i++) begin
            drv(1'b1, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            chk("fill_dout_head", 32'(if_dout), 32'h11);
            chk("fill_count", 32'(if_count), 32'(i + 1));
        end
        chk("full_full_n", 32'(if_full_n), 0);

        // Full: write dropped, read accepted.
        drv(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
        chk("full_rw_count", 32'(if_count), 4);
        chk("full_rw_dout", 32'(if_dout), 32'h12);

        drv(1'b0, 1'b0, '0, 1'b1, 1'b1);
        drv(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("steady_start_count", 32'(if_count), 2);

        // Simultaneous read+write at count 2.
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 1'b1, 8'(8'h30 + i), 1'b1, 1'b1);
            chk("steady_count", 32'(if_count), 2);
        end

        drv(1'b0, 1'b0, '0, 1'b1, 1'b1);
        drv(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("drained_empty_n", 32'(if_empty_n), 0);

        // Empty: read ignored, write accepted.
        drv(1'b1, 1'b1, 8'h5C, 1'b1, 1'b1);
        chk("empty_rw_empty_n", 32'(if_empty_n), 1);
        chk("empty_rw_dout", 32'(if_dout), 32'h5C);
        chk("empty_rw_count", 32'(if_count), 1);
        chk("empty_rw_ae", 32'(if_almost_empty), 1);

        // Clock-enable low ignores requests.
        drv(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        drv(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("ce_low_count", 32'(if_count), 1);

        drv(1'b1, 1'b1, 8'h61, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 8'h62, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(if_count), 3);
        if_write = 1'b0;
        if_write_ce = 1'b0;

        // Asynchronous reset between edges.
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(if_count), 0);
        chk("async_rst_empty_n", 32'(if_empty_n), 0);
        chk("async_rst_full_n", 32'(if_full_n), 1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drv(1'b1, 1'b1, 8'h9E, 1'b0, 1'b0);
        chk("post_rst_dout", 32'(if_dout), 32'h9E);

`ifdef KERNEL_CC_FIFO_ERR_EN
        for (int i = 0; i < DEPTH - 1; i++) drv(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        drv(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_set", 32'(if_overflow), 1);
        for (int i = 0; i < DEPTH + 1; i++) drv(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("unf_set", 32'(if_underflow), 1);
        repeat (3) idle();
        chk("ovf_sticky", 32'(if_overflow), 1);
        chk("unf_sticky", 32'(if_underflow), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ovf_clr", 32'(if_overflow), 0);
        chk("unf_clr", 32'(if_underflow), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
`endif

        // Random traffic with occasional mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                idle();
                reset_n = 1'b1;
            end else begin
                drv(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 85), 8'($urandom),
                    1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 85));
            end
        end
        repeat (2) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_cc_fifo_srl_param.md
Name: kernel_cc_fifo_srl_param

Overview:
Parametrised shift-register FIFO for kernel_cc dataflow channels. It generalises the fixed w32/d32 stream FIFO in three ways: any DATA_WIDTH, any DEPTH (power of two not required), and an occupancy count with registered almost-full/almost-empty flags for upstream throttling. It keeps first-word-fall-through (FWFT) semantics and the if_* handshake used between HLS kernel stages.

Parameters:
DATA_WIDTH, 32, word width in bits (>=1)
DEPTH, 32, number of entries (>=2, any integer)
ADDR_WIDTH, $clog2(DEPTH), shift-register index width (derived; not overridden)
AF_THRESH, DEPTH-2, if_almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, if_almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_din  in  DATA_WIDTH  write data
if_write  in  1  write request
if_write_ce  in  1  write clock-enable; a write is accepted when if_write & if_write_ce & if_full_n
if_full_n  out  1  1 = space available
if_dout  out  DATA_WIDTH  head-of-queue data (FWFT), valid while if_empty_n=1
if_read  in  1  read request
if_read_ce  in  1  read clock-enable; a read is accepted when if_read & if_read_ce & if_empty_n
if_empty_n  out  1  1 = data available
if_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
if_almost_full  out  1  registered, count >= AF_THRESH
if_almost_empty  out  1  registered, count <= AE_THRESH

Behaviour:
- Reset (reset_n=0, asynchronous assert, synchronous release): count=0, if_empty_n=0, if_full_n=1, if_almost_full=0, if_almost_empty=1. Storage array is not reset. if_dout is don't-care while empty.
- wr_acc = if_write & if_write_ce & if_full_n; rd_acc = if_read & if_read_ce & if_empty_n.
- Storage: on wr_acc, every entry shifts up one position and entry 0 takes if_din. Read address = count-1 when count>0, else 0. if_dout = entry[addr] combinationally, so latency from write to data visible at if_dout is 1 cycle.
- Occupancy update:
  - wr_acc only: count+1.
  - rd_acc only: count-1.
  - both: count unchanged, shift still occurs, and the head advances correctly.
  - neither: hold.
- All flags are registered from next-count:
  - if_empty_n = (next!=0)
  - if_full_n = (next!=DEPTH)
  - if_almost_full = (next>=AF_THRESH)
  - if_almost_empty = (next<=AE_THRESH)
- Full: a write is ignored (no shift, no count change). A simultaneous read is accepted and yields DEPTH-1. The freed slot becomes writable the next cycle.
- Empty: a read is ignored. A simultaneous write is accepted and yields count=1 with if_empty_n=1 the next cycle.
- Non-power-of-two DEPTH: count never exceeds DEPTH. Addresses >= DEPTH are never generated.
- Reset asserted mid-stream: flags and count return to reset values immediately. Contents are lost logically.
- ce low: request ignored exactly as if the request were deasserted.
- Elaboration check: DEPTH<2, AF_THRESH outside 1..DEPTH, or AE_THRESH outside 0..DEPTH-1 raises a fatal error.

Optional Feature:
Macro KERNEL_CC_FIFO_ERR_EN.
- Defined: adds outputs if_overflow and if_underflow (1 bit each, sticky, cleared only by reset).
  - if_overflow sets one cycle after if_write & if_write_ce while if_full_n=0.
  - if_underflow sets one cycle after if_read & if_read_ce while if_empty_n=0.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package kernel_cc_fifo_pkg holds:
  - function fifo_addr_w(depth) (clog2, min 1)
  - function fifo_cnt_w(depth) = addr_w+1
  - localparam defaults for DATA_WIDTH and DEPTH
- Sub-module kernel_cc_fifo_srl_param_shiftreg (ports clk, data, ce, a, q; params DATA_WIDTH, ADDR_WIDTH, DEPTH): the pure SRL array with no reset.
- The top level holds the count, flags, and optional error logic.

Test Plan:
- DEPTH=5, DATA_WIDTH=8, AF_THRESH=4, AE_THRESH=1. After reset, write 0x11..0x15 on consecutive cycles:
  - if_count 1..5.
  - if_almost_full rises the cycle after the 4th write.
  - if_full_n=0 after the 5th.
  - if_dout=0x11 from the cycle after the first write.
- Full FIFO, write 0xAA + read in the same cycle:
  - write dropped, read accepted, count=4.
  - if_dout=0x12.
  - 0xAA never appears on if_dout.
- Count=2, write+read every cycle for 10 cycles with ramp data:
  - count stays 2, flags stable.
  - if_dout presents words in order with no loss or duplication.
- Empty FIFO, read+write 0x5C together:
  - read ignored.
  - next cycle if_empty_n=1, if_dout=0x5C, count=1, if_almost_empty=1.
- Count=3, pull reset_n low mid-cycle (between edges):
  - if_empty_n=0, if_full_n=1, count=0 immediately without waiting for a clock edge.
  - after release, 1 write gives if_dout equal to the new word.
- With KERNEL_CC_FIFO_ERR_EN:
  - write into a full FIFO sets if_overflow the next cycle.
  - read from an empty FIFO sets if_underflow.
  - both stay set until reset_n=0.
